// File: rtl/vscale_hasti_sram_slave.sv
// AHB-Lite (HASTI) SRAM slave: word-wide memory with byte/half writes,
// programmable wait states and a two-cycle ERROR response for bad transfers.
module vscale_hasti_sram_slave #(
   parameter int NWORDS      = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp,
   output logic [2:0]  fsm_state
);

   localparam int          AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [31:0] NWORDS_W  = 32'(NWORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_DONE = 3'd2;
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [2:0]    launch_state;
   logic [3:0]    wait_cnt;
   logic [31:0]   addr_q;
   logic          write_q;
   logic [2:0]    size_q;
   logic          accept;
   logic          xfer_err;
   logic [AW-1:0] word_idx;
   logic [3:0]    byte_en;
   logic [31:0]   mem [NWORDS];
   logic          unused_ok;

   // Handshake: a transfer is taken on a rising edge when hready is high and
   // htrans is NONSEQ/SEQ; the data phase ends on the first cycle with hready high.
   assign hready    = (state != ST_WAIT) && (state != ST_ERR1);
   assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);
   assign accept    = hready && htrans[1];
   assign fsm_state = state;
   assign word_idx  = addr_q[AW+1:2];
   assign unused_ok = ^{hburst, hmastlock, hprot, addr_q};

   always_comb begin
      xfer_err = 1'b0;
      if ({2'b00, haddr[31:2]} >= NWORDS_W) begin
         xfer_err = 1'b1;
      end
      case (hsize)
         3'd0:    ;
         3'd1:    if (haddr[0]) xfer_err = 1'b1;
         3'd2:    if (haddr[1:0] != 2'b00) xfer_err = 1'b1;
         default: xfer_err = 1'b1;
      endcase
   end

   always_comb begin
      launch_state = ST_DONE;
      if (xfer_err) begin
         launch_state = ST_ERR1;
      end else if (WAIT_CYCLES > 0) begin
         launch_state = ST_WAIT;
      end
   end

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_WAIT: state_nxt = (wait_cnt == 4'd0) ? ST_DONE : ST_WAIT;
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = accept ? launch_state : ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= 32'd0;
         write_q  <= 1'b0;
         size_q   <= 3'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            size_q  <= hsize;
         end
         if (accept && !xfer_err && (WAIT_CYCLES > 0)) begin
            wait_cnt <= WAIT_LOAD;
         end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // Byte lanes follow the little-endian AHB data bus layout.
   always_comb begin
      case (size_q)
         3'd0:    byte_en = 4'b0001 << addr_q[1:0];
         3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   // The write lands at the end of DONE, so a read in the very next data phase sees it.
   always_ff @(posedge hclk) begin
      if ((state == ST_DONE) && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[word_idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
         end
      end
   end

   assign hrdata = ((state == ST_DONE) && !write_q) ? mem[word_idx] : 32'd0;

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Bench for the HASTI SRAM slave: two instances (no wait states / 3 wait states),
// directed vector tables, randomized traffic against a byte-level memory model.
module tb_vscale_hasti_sram_slave;

   localparam int NW0 = 1024;
   localparam int NW1 = 64;
   localparam int REGION = 128;

   typedef struct {
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        use_tbl;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   // clock / reset
   logic hclk = 1'b0;
   always #5 hclk = ~hclk;
   logic [1:0] rst_n;

   logic [1:0][31:0] haddr_p;
   logic [1:0][31:0] hwdata_p;
   logic [1:0]       hwrite_p;
   logic [1:0]       hmastlock_p;
   logic [1:0][2:0]  hsize_p;
   logic [1:0][2:0]  hburst_p;
   logic [1:0][3:0]  hprot_p;
   logic [1:0][1:0]  htrans_p;

   logic [31:0] hrdata0, hrdata1;
   logic        hready0, hready1, hresp0, hresp1;
   logic [2:0]  st0, st1;

   vscale_hasti_sram_slave #(.NWORDS(NW0), .WAIT_CYCLES(0)) dut0 (
      .hclk(hclk), .hresetn(rst_n[0]), .haddr(haddr_p[0]), .hwrite(hwrite_p[0]),
      .hsize(hsize_p[0]), .hburst(hburst_p[0]), .hmastlock(hmastlock_p[0]),
      .hprot(hprot_p[0]), .htrans(htrans_p[0]), .hwdata(hwdata_p[0]),
      .hrdata(hrdata0), .hready(hready0), .hresp(hresp0), .fsm_state(st0)
   );

   vscale_hasti_sram_slave #(.NWORDS(NW1), .WAIT_CYCLES(3)) dut1 (
      .hclk(hclk), .hresetn(rst_n[1]), .haddr(haddr_p[1]), .hwrite(hwrite_p[1]),
      .hsize(hsize_p[1]), .hburst(hburst_p[1]), .hmastlock(hmastlock_p[1]),
      .hprot(hprot_p[1]), .htrans(htrans_p[1]), .hwdata(hwdata_p[1]),
      .hrdata(hrdata1), .hready(hready1), .hresp(hresp1), .fsm_state(st1)
   );

   // scoreboard state
   int total = 0;
   int bad = 0;
   logic [33:0] exp_q[$];
   vec_t items_q[$];
   logic [7:0] mb [2][REGION];
   vec_t dir0 [20];
   vec_t dir1 [11];

   localparam logic [33:0] IDLE_RESP = {1'b1, 1'b0, 32'd0};

   task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t: got ready=%0b resp=%0b rdata=%h, want ready=%0b resp=%0b rdata=%h",
                  name, $time, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t: got %h, want %h", name, $time, got, exp);
      end
   endtask

   function automatic logic [33:0] observe(input int d);
      return (d == 0) ? {hready0, hresp0, hrdata0} : {hready1, hresp1, hrdata1};
   endfunction

   // reference model
   function automatic int nwords(input int d);
      return (d == 0) ? NW0 : NW1;
   endfunction

   function automatic int waits(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit model_err(input int d, input logic [31:0] a, input logic [2:0] s);
      longint widx;
      int nbytes;
      widx = longint'({32'd0, a}) / 4;
      if (widx >= longint'(nwords(d))) return 1'b1;
      if (s > 3'd2) return 1'b1;
      nbytes = 1 << s;
      if ((int'(a[7:0]) % nbytes) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
      int base;
      base = (int'(a) / 4) * 4;
      return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
   endfunction

   task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] wd);
      int ba;
      int lane;
      for (int k = 0; k < (1 << s); k++) begin
         ba = int'(a) + k;
         lane = ba % 4;
         mb[d][ba] = wd[8*lane +: 8];
      end
   endtask

   task automatic accept_item(input int d, input vec_t it);
      bit err;
      logic [31:0] rd;
      err = it.use_tbl ? it.exp_err : model_err(d, it.addr, it.size);
      if (err) begin
         exp_q.push_back({1'b0, 1'b1, 32'd0});
         exp_q.push_back({1'b1, 1'b1, 32'd0});
      end else begin
         for (int w = 0; w < waits(d); w++) exp_q.push_back({1'b0, 1'b0, 32'd0});
         if (it.wr) begin
            model_write(d, it.addr, it.size, it.wdata);
            exp_q.push_back(IDLE_RESP);
         end else begin
            rd = it.use_tbl ? it.exp_rdata : model_read(d, it.addr);
            exp_q.push_back({1'b1, 1'b0, rd});
         end
      end
   endtask

   function automatic vec_t mk(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic tbl, input logic er, input logic [31:0] rd);
      vec_t v;
      v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
      v.use_tbl = tbl; v.exp_err = er; v.exp_rdata = rd;
      return v;
   endfunction

   // driver: called at posedge+1, one loop pass per clock cycle
   task automatic run_items(input int d);
      int guard;
      logic issued;
      logic [31:0] pend_wd;
      logic [33:0] o;
      logic [33:0] e;
      vec_t it;
      guard = 0;
      issued = 1'b0;
      pend_wd = 32'd0;
      while ((items_q.size() > 0 || exp_q.size() > 0 || issued) && guard < 20000) begin
         o = observe(d);
         e = IDLE_RESP;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         check("data_phase", o, e);
         if (issued) begin
            hwdata_p[d] = pend_wd;
            issued = 1'b0;
         end
         hburst_p[d]    = 3'($urandom_range(0, 7));
         hprot_p[d]     = 4'($urandom_range(0, 15));
         hmastlock_p[d] = 1'($urandom_range(0, 1));
         if (o[33] && items_q.size() > 0) begin
            it = items_q.pop_front();
            htrans_p[d] = it.trans;
            hwrite_p[d] = it.wr;
            hsize_p[d]  = it.size;
            haddr_p[d]  = it.addr;
            if (it.trans[1]) begin
               accept_item(d, it);
               pend_wd = it.wdata;
               issued = 1'b1;
            end
         end else if (!o[33]) begin
            htrans_p[d] = 2'd2;
            hwrite_p[d] = 1'b1;
            hsize_p[d]  = 3'd2;
            haddr_p[d]  = 32'($urandom_range(0, REGION / 4 - 1) * 4);
         end else begin
            htrans_p[d] = 2'd0;
         end
         @(posedge hclk);
         #1;
         guard++;
      end
      if (guard >= 20000) begin
         total++;
         bad++;
         $display("FAIL run_timeout dut%0d: got %0d cycles, want completion", d, guard);
         exp_q.delete();
         items_q.delete();
      end
      htrans_p[d] = 2'd0;
   endtask

   task automatic gen_random(input int d, input int n);
      vec_t v;
      int r;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         v.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
         v.wr = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         v.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
         if ($urandom_range(0, 4) == 0) begin
            v.addr = ($urandom_range(0, 1) == 0) ? 32'(nwords(d) * 4 + $urandom_range(0, 4095))
                                                 : 32'h8000_0000 | $urandom;
         end else begin
            v.addr = 32'($urandom_range(0, REGION - 1));
         end
         v.wdata = $urandom;
         v.use_tbl = 1'b0;
         v.exp_err = 1'b0;
         v.exp_rdata = 32'd0;
         items_q.push_back(v);
      end
   endtask

   task automatic fill_region(input int d);
      for (int w = 0; w < REGION / 4; w++) begin
         items_q.push_back(mk(2'd2, 1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0, 1'b0, 32'd0));
      end
   endtask

   // write to 0x30 on the wait-state instance, reset lands mid-WAIT
   task automatic reset_mid_wait();
      haddr_p[1] = 32'h30; hwrite_p[1] = 1'b1; hsize_p[1] = 3'd2; htrans_p[1] = 2'd2;
      @(posedge hclk); #1;
      htrans_p[1] = 2'd0;
      hwdata_p[1] = 32'hFFFF_0000;
      check("rst_wait_entry", observe(1), {1'b0, 1'b0, 32'd0});
      @(posedge hclk); #1;
      check("rst_wait_mid", observe(1), {1'b0, 1'b0, 32'd0});
      #2 rst_n[1] = 1'b0;
      #1;
      check("rst_async", observe(1), IDLE_RESP);
      check_val("rst_state", {29'd0, st1}, 32'd0);
      repeat (4) @(posedge hclk);
      #1;
      check("rst_held", observe(1), IDLE_RESP);
      rst_n[1] = 1'b1;
      items_q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h30, 32'd0, 1'b0, 1'b0, 32'd0));
      run_items(1);
   endtask

   initial begin
      dir0[0]  = mk(2'd2, 1'b1, 3'd2, 32'h00,       32'h0BAD_F00D, 1'b1, 1'b0, 32'd0);
      dir0[1]  = mk(2'd2, 1'b1, 3'd2, 32'h10,       32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
      dir0[2]  = mk(2'd2, 1'b0, 3'd2, 32'h10,       32'd0,         1'b1, 1'b0, 32'hDEAD_BEEF);
      dir0[3]  = mk(2'd3, 1'b1, 3'd2, 32'h20,       32'h1122_3344, 1'b1, 1'b0, 32'd0);
      dir0[4]  = mk(2'd2, 1'b1, 3'd0, 32'h21,       32'hCCCC_AACC, 1'b1, 1'b0, 32'd0);
      dir0[5]  = mk(2'd2, 1'b0, 3'd2, 32'h20,       32'd0,         1'b1, 1'b0, 32'h1122_AA44);
      dir0[6]  = mk(2'd2, 1'b1, 3'd2, 32'h1000,     32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
      dir0[7]  = mk(2'd2, 1'b0, 3'd2, 32'h00,       32'd0,         1'b1, 1'b0, 32'h0BAD_F00D);
      dir0[8]  = mk(2'd2, 1'b0, 3'd2, 32'h02,       32'd0,         1'b1, 1'b1, 32'd0);
      dir0[9]  = mk(2'd2, 1'b1, 3'd2, 32'h02,       32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
      dir0[10] = mk(2'd1, 1'b1, 3'd2, 32'h10,       32'h1234_5678, 1'b1, 1'b0, 32'd0);
      dir0[11] = mk(2'd0, 1'b1, 3'd2, 32'h10,       32'h1234_5678, 1'b1, 1'b0, 32'd0);
      dir0[12] = mk(2'd2, 1'b0, 3'd2, 32'h00,       32'd0,         1'b1, 1'b0, 32'h0BAD_F00D);
      dir0[13] = mk(2'd2, 1'b1, 3'd1, 32'h12,       32'h5566_7788, 1'b1, 1'b0, 32'd0);
      dir0[14] = mk(2'd2, 1'b0, 3'd2, 32'h10,       32'd0,         1'b1, 1'b0, 32'h5566_BEEF);
      dir0[15] = mk(2'd2, 1'b1, 3'd1, 32'h11,       32'd0,         1'b1, 1'b1, 32'd0);
      dir0[16] = mk(2'd2, 1'b0, 3'd3, 32'h10,       32'd0,         1'b1, 1'b1, 32'd0);
      dir0[17] = mk(2'd3, 1'b1, 3'd0, 32'h13,       32'h9900_0000, 1'b1, 1'b0, 32'd0);
      dir0[18] = mk(2'd2, 1'b0, 3'd1, 32'h12,       32'd0,         1'b1, 1'b0, 32'h9966_BEEF);
      dir0[19] = mk(2'd2, 1'b1, 3'd2, 32'hFFFF_FFFC, 32'h0,        1'b1, 1'b1, 32'd0);

      dir1[0]  = mk(2'd2, 1'b1, 3'd2, 32'h00,  32'hA5A5_0F0F, 1'b1, 1'b0, 32'd0);
      dir1[1]  = mk(2'd2, 1'b0, 3'd2, 32'h00,  32'd0,         1'b1, 1'b0, 32'hA5A5_0F0F);
      dir1[2]  = mk(2'd2, 1'b1, 3'd2, 32'h100, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
      dir1[3]  = mk(2'd2, 1'b1, 3'd2, 32'h7C,  32'h1234_ABCD, 1'b1, 1'b0, 32'd0);
      dir1[4]  = mk(2'd3, 1'b0, 3'd2, 32'h7C,  32'd0,         1'b1, 1'b0, 32'h1234_ABCD);
      dir1[5]  = mk(2'd2, 1'b1, 3'd0, 32'h103, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
      dir1[6]  = mk(2'd2, 1'b0, 3'd2, 32'h00,  32'd0,         1'b1, 1'b0, 32'hA5A5_0F0F);
      dir1[7]  = mk(2'd1, 1'b1, 3'd2, 32'h00,  32'h0,         1'b1, 1'b0, 32'd0);
      dir1[8]  = mk(2'd2, 1'b1, 3'd1, 32'h02,  32'h7777_0000, 1'b1, 1'b0, 32'd0);
      dir1[9]  = mk(2'd2, 1'b0, 3'd0, 32'h01,  32'd0,         1'b1, 1'b0, 32'h7777_0F0F);
      dir1[10] = mk(2'd2, 1'b0, 3'd2, 32'h06,  32'd0,         1'b1, 1'b1, 32'd0);

      rst_n = 2'b00;
      haddr_p = '0; hwdata_p = '0; hwrite_p = '0; hmastlock_p = '0;
      hsize_p = '0; hburst_p = '0; hprot_p = '0; htrans_p = '0;
      #1;
      check("reset_dut0", observe(0), IDLE_RESP);
      check("reset_dut1", observe(1), IDLE_RESP);
      repeat (3) @(posedge hclk);
      #1;
      rst_n = 2'b11;

      for (int d = 0; d < 2; d++) begin
         fill_region(d);
         if (d == 0) begin
            for (int i = 0; i < 20; i++) items_q.push_back(dir0[i]);
         end else begin
            for (int i = 0; i < 11; i++) items_q.push_back(dir1[i]);
         end
         run_items(d);
         gen_random(d, 250);
         run_items(d);
      end

      reset_mid_wait();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vscale_hasti_sram_slave.md
VSCALE_HASTI_SRAM_SLAVE -- requirements
Module: vscale_hasti_sram_slave

Interface
REQ-001 The module SHALL have parameter NWORDS, default 1024, giving the memory depth in 32-bit words.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 0, giving the number of wait states (0..15) inserted before each OKAY completion.
REQ-003 The module SHALL have port hclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port hresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port haddr, input, 32 bits: address-phase byte address.
REQ-006 The module SHALL have port hwrite, input, 1 bit: address-phase direction, 1 = write.
REQ-007 The module SHALL have port hsize, input, 3 bits: transfer size (0 = byte, 1 = half, 2 = word).
REQ-008 The module SHALL have ports hburst (3 bits), hmastlock (1 bit) and hprot (4 bits), all inputs, all accepted and ignored.
REQ-009 The module SHALL have port htrans, input, 2 bits: IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
REQ-010 The module SHALL have port hwdata, input, 32 bits: data-phase write data.
REQ-011 The module SHALL have port hrdata, output, 32 bits: data-phase read data.
REQ-012 The module SHALL have port hready, output, 1 bit: data-phase completion / address-phase accept.
REQ-013 The module SHALL have port hresp, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-014 An address phase SHALL be accepted on a rising edge only when hready = 1 and htrans is NONSEQ or SEQ; on acceptance the module SHALL register haddr, hwrite and hsize.
REQ-015 IDLE/BUSY address phases, and any address phase seen while hready = 0, SHALL be ignored.
REQ-016 The FSM SHALL have the states IDLE, WAIT, DONE, ERR1 and ERR2.
REQ-017 Outputs per state SHALL be: IDLE and DONE drive hready = 1, hresp = 0; WAIT drives hready = 0, hresp = 0; ERR1 drives hready = 0, hresp = 1; ERR2 drives hready = 1, hresp = 1.
REQ-018 An accepted transfer SHALL be erroneous if any of the following holds: word index haddr[31:2] >= NWORDS; hsize > 2; hsize = 1 with haddr[0] = 1; hsize = 2 with haddr[1:0] != 0.
REQ-019 On acceptance, the next state SHALL be ERR1 if the transfer is erroneous; otherwise WAIT if WAIT_CYCLES > 0 (wait counter loaded with WAIT_CYCLES-1); otherwise DONE.
REQ-020 WAIT SHALL decrement the counter each cycle and go to DONE when the counter is 0, so that exactly WAIT_CYCLES hready = 0 cycles precede DONE.
REQ-021 ERR1 SHALL always go to ERR2.
REQ-022 From IDLE, DONE or ERR2, the FSM SHALL follow REQ-019 if a new transfer is accepted and otherwise go to IDLE, so back-to-back transfers are pipelined with no bubble.
REQ-023 A write SHALL update memory at the end of the DONE cycle, using hwdata sampled in that cycle, writing only the byte lanes selected by the registered hsize and haddr[1:0].
REQ-024 Erroneous writes SHALL never modify memory.
REQ-025 hrdata SHALL equal the full word mem[registered word index] during DONE of a read, and 0 in all other cycles.
REQ-026 A read whose data phase immediately follows a write's DONE SHALL return the newly written data.
REQ-027 Memory SHALL be inferable as single-port synchronous-write RAM with an asynchronous read from the registered index.

Reset
REQ-028 Asserting hresetn = 0 SHALL immediately force state = IDLE, wait counter = 0, registered address/control = 0, hready = 1, hresp = 0 and hrdata = 0.
REQ-029 A transfer in progress at reset assertion SHALL be abandoned and, if it is a write, SHALL leave memory unchanged.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 The first address phase SHALL be accepted on the first rising edge with hresetn = 1.

Verification
REQ-032 Word write then read, WAIT_CYCLES = 0: NONSEQ write 0x10 with data 0xDEADBEEF, then NONSEQ read 0x10 -> hready stays 1 throughout and the read DONE shows hrdata = 0xDEADBEEF, hresp = 0.
REQ-033 Byte lanes: word 0x20 preset to 0x11223344; byte write 0xAA to 0x21, then word read of 0x20 -> hrdata = 0x1122AA44.
REQ-034 Wait states, WAIT_CYCLES = 3: read 0x0 -> exactly 3 cycles of hready = 0 follow acceptance, then 1 cycle of hready = 1 carrying the data.
REQ-035 Error response, NWORDS = 1024: write to 0x1000 -> one cycle of hready = 0, hresp = 1, then one cycle of hready = 1, hresp = 1, and memory is unchanged; a misaligned word access at 0x2 gives the same response.
REQ-036 IDLE/BUSY: htrans = BUSY with hwrite = 1 -> no state change, hready = 1, memory untouched.
REQ-037 Reset during WAIT, WAIT_CYCLES = 3: drop hresetn mid-WAIT during a write to 0x30 -> hready = 1 and hrdata = 0 asynchronously, and a later read of 0x30 returns the prior contents.
